// File: rtl/alu32_pkg.sv
// Shared ALU32 definitions: FSM encoding, rotation directions and the
// shortest-path resolution of an undo rotation.
package alu32_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  typedef struct packed {
    logic       dir;
    logic [4:0] k;
  } plan_t;

  // Undo runs opposite to the original rotation; beyond half a word the
  // other way round is shorter, and 32-a wraps to 0 for a=0.
  function automatic plan_t resolve_plan(input logic [WORD_W-1:0] ctl);
    plan_t      p;
    logic [4:0] a;
    logic       undo_dir;
    a        = ctl[4:0];
    undo_dir = ctl[WORD_W-1] ? DIR_LEFT : DIR_RIGHT;
    if (a <= 5'd16) begin
      p.dir = undo_dir;
      p.k   = a;
    end else begin
      p.dir = ~undo_dir;
      p.k   = 5'd0 - a;
    end
    return p;
  endfunction

endpackage

// File: rtl/rot_step32.sv
// Combinational rotate of a 32-bit word by 0..8 bits, left or right.
module rot_step32
  import alu32_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  input  logic [3:0]        amt,
  input  logic              dir,
  output logic [WORD_W-1:0] dout
);

  logic [2*WORD_W-1:0] dbl;
  logic [2*WORD_W-1:0] shl;
  logic [2*WORD_W-1:0] shr;

  always_comb begin
    dbl  = {din, din};
    shl  = dbl << amt;
    shr  = dbl >> amt;
    dout = (dir == DIR_LEFT) ? shl[2*WORD_W-1:WORD_W] : shr[WORD_W-1:0];
  end

endmodule

// File: rtl/rot_restore32.sv
// Iterative inverse rotator: restores a word rotated by the ALU32 truncate/
// rotate unit, at most STEP bits per cycle, using a start/busy/done handshake.
module rot_restore32
  import alu32_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] In1,
  input  logic [WORD_W-1:0] In2,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] cout1
);

  localparam logic [3:0] STEP_AMT = 4'(STEP);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] work_q, work_d;
  logic              dir_q, dir_d;
  logic [4:0]        rem_q, rem_d;
  logic [WORD_W-1:0] cout_q, cout_d;

  plan_t             plan;
  logic [3:0]        step_amt;
  logic [4:0]        rem_next;
  logic [WORD_W-1:0] rot_out;

  always_comb begin
    step_amt = (rem_q < {1'b0, STEP_AMT}) ? rem_q[3:0] : STEP_AMT;
    rem_next = rem_q - {1'b0, step_amt};
  end

  rot_step32 u_step (
    .din  (work_q),
    .amt  (step_amt),
    .dir  (dir_q),
    .dout (rot_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    cout_d  = cout_q;
    plan    = resolve_plan(In2);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          work_d = In1;
          dir_d  = plan.dir;
          rem_d  = plan.k;
          if (plan.k == 5'd0) begin
            state_d = S_DONE;
            cout_d  = In1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        work_d = rot_out;
        rem_d  = rem_next;
        // cout1 is loaded on entry so it is already valid while done is high
        if (rem_next == 5'd0) begin
          state_d = S_DONE;
          cout_d  = rot_out;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      dir_q   <= DIR_LEFT;
      rem_q   <= '0;
      cout_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      cout_q  <= cout_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign cout1 = cout_q;

endmodule

// File: tb/tb_rot_restore32.sv
// Directed bench for rot_restore32; a STEP=1 and a STEP=4 instance share inputs.
module tb_rot_restore32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] In1 = '0;
  logic [31:0] In2 = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] cout1_1, cout1_4;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rot_restore32 #(.STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .In1(In1), .In2(In2),
    .busy(busy1), .done(done1), .cout1(cout1_1)
  );

  rot_restore32 #(.STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .In1(In1), .In2(In2),
    .busy(busy4), .done(done4), .cout1(cout1_4)
  );

  // Start cycle t is the cycle in which start is driven; n counts cycles after it.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                         output int c1, output int c4,
                         output logic [31:0] o1, output logic [31:0] o4,
                         output bit busy_ok);
    c1 = 0; c4 = 0; o1 = '0; o4 = '0; busy_ok = 1'b1;
    @(negedge clk);
    In1 = a; In2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; In1 = 32'hFFFF_FFFF; In2 = 32'h7FFF_FFE3;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (c1 == 0) begin
        if (!busy1) busy_ok = 1'b0;
        if (done1) begin c1 = n; o1 = cout1_1; end
      end
      if (c4 == 0 && done4) begin c4 = n; o4 = cout1_4; end
      if (c1 != 0 && c4 != 0) break;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if ({busy1, done1, busy4, done4} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {busy1, done1, busy4, done4}); end
    tests_run++; if (cout1_1 !== 32'h0 || cout1_4 !== 32'h0) begin fails++; $display("FAIL reset_cout got %h/%h exp 0", cout1_1, cout1_4); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_left4();
    int c1, c4; logic [31:0] o1, o4; bit bok;
    run_job(32'h8000_0001, 32'h8000_0004, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 5) begin fails++; $display("FAIL left4_lat1 got %0d exp 5", c1); end
    tests_run++; if (o1 !== 32'h0000_0018) begin fails++; $display("FAIL left4_cout1 got %h exp 00000018", o1); end
    tests_run++; if (bok !== 1'b1) begin fails++; $display("FAIL left4_busy got %b exp 1", bok); end
    tests_run++; if (c4 !== 2 || o4 !== 32'h0000_0018) begin fails++; $display("FAIL left4_step4 got %0d/%h exp 2/00000018", c4, o4); end
    tests_run++; if (busy1 !== 1'b0 || cout1_1 !== 32'h0000_0018) begin fails++; $display("FAIL left4_hold got %b/%h exp 0/00000018", busy1, cout1_1); end
  endtask

  task automatic test_shortest();
    int c1, c4; logic [31:0] o1, o4; bit bok;
    run_job(32'h8000_0001, 32'h0000_001C, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 5 || o1 !== 32'h0000_0018) begin fails++; $display("FAIL short28 got %0d/%h exp 5/00000018", c1, o1); end
    run_job(32'h1234_5678, 32'h8000_0011, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 16 || o1 !== 32'hACF0_2468) begin fails++; $display("FAIL short17_s1 got %0d/%h exp 16/acf02468", c1, o1); end
    tests_run++; if (c4 !== 5 || o4 !== 32'hACF0_2468) begin fails++; $display("FAIL short17_s4 got %0d/%h exp 5/acf02468", c4, o4); end
  endtask

  task automatic test_zero();
    int c1, c4; logic [31:0] o1, o4; bit bok;
    run_job(32'h1234_5678, 32'h8000_0000, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 1 || o1 !== 32'h1234_5678) begin fails++; $display("FAIL zero_s1 got %0d/%h exp 1/12345678", c1, o1); end
    tests_run++; if (c4 !== 1 || o4 !== 32'h1234_5678) begin fails++; $display("FAIL zero_s4 got %0d/%h exp 1/12345678", c4, o4); end
  endtask

  task automatic test_half();
    int c1, c4; logic [31:0] o1, o4; bit bok;
    run_job(32'h1234_5678, 32'h0000_0010, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 17 || o1 !== 32'h5678_1234) begin fails++; $display("FAIL half_s1 got %0d/%h exp 17/56781234", c1, o1); end
    tests_run++; if (c4 !== 5 || o4 !== 32'h5678_1234) begin fails++; $display("FAIL half_s4 got %0d/%h exp 5/56781234", c4, o4); end
  endtask

  task automatic test_back_to_back();
    int c1, c4; bit extra4;
    logic [31:0] o1, o4;
    c1 = 0; c4 = 0; o1 = '0; o4 = '0; extra4 = 1'b0;
    @(negedge clk);
    In1 = 32'hDEAD_BEEF; In2 = 32'h8000_0008; start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = (n == 3);
      if (n == 3) begin In1 = 32'h0; In2 = 32'h8000_0004; end
      if (n == 4) In1 = 32'h0;
      if (done1 && c1 == 0) begin c1 = n; o1 = cout1_1; end
      if (done4 && c4 == 0) begin c4 = n; o4 = cout1_4; end
      else if (n > 3 && (busy4 || done4)) extra4 = 1'b1;
    end
    start = 1'b0;
    tests_run++; if (c1 !== 9 || o1 !== 32'hADBE_EFDE) begin fails++; $display("FAIL b2b_s1 got %0d/%h exp 9/adbeefde", c1, o1); end
    tests_run++; if (c4 !== 3 || o4 !== 32'hADBE_EFDE) begin fails++; $display("FAIL b2b_s4 got %0d/%h exp 3/adbeefde", c4, o4); end
    tests_run++; if (extra4 !== 1'b0) begin fails++; $display("FAIL b2b_start_on_done got %b exp 0", extra4); end
    tests_run++; if (cout1_4 !== 32'hADBE_EFDE) begin fails++; $display("FAIL b2b_hold got %h exp adbeefde", cout1_4); end
  endtask

  task automatic test_reset_mid();
    int c1, c4; logic [31:0] o1, o4; bit bok;
    @(negedge clk);
    In1 = 32'h1234_5678; In2 = 32'h0000_0010; start = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    tests_run++; if (busy1 !== 1'b1 || done4 !== 1'b1) begin fails++; $display("FAIL mid_pre got %b/%b exp 1/1", busy1, done4); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({busy1, done1, busy4, done4} !== 4'b0) begin fails++; $display("FAIL mid_async_flags got %b exp 0000", {busy1, done1, busy4, done4}); end
    tests_run++; if (cout1_1 !== 32'h0 || cout1_4 !== 32'h0) begin fails++; $display("FAIL mid_async_cout got %h/%h exp 0", cout1_1, cout1_4); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (busy1 !== 1'b0 || busy4 !== 1'b0) begin fails++; $display("FAIL mid_idle got %b/%b exp 0/0", busy1, busy4); end
    run_job(32'h0000_0001, 32'h8000_0001, c1, c4, o1, o4, bok);
    tests_run++; if (c1 !== 2 || o1 !== 32'h0000_0002) begin fails++; $display("FAIL mid_after_s1 got %0d/%h exp 2/00000002", c1, o1); end
    tests_run++; if (c4 !== 2 || o4 !== 32'h0000_0002) begin fails++; $display("FAIL mid_after_s4 got %0d/%h exp 2/00000002", c4, o4); end
  endtask

  initial begin
    test_reset();
    test_left4();
    test_shortest();
    test_zero();
    test_half();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
